// File: rtl/seg_scan_scheduler.sv
// Two-digit seven-segment scan scheduler: BLANK0 -> SHOW0 -> BLANK1 -> SHOW1,
// with a dark gap before each digit so the shared segment bus never ghosts.
module seg_scan_scheduler #(
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int MAX_LEN = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    hold;
  logic [3:0]    s0_meta, s0_sync, s1_meta, s1_sync;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_meta <= '0;
      s0_sync <= '0;
      s1_meta <= '0;
      s1_sync <= '0;
    end else begin
      s0_meta <= s0;
      s0_sync <= s0_meta;
      s1_meta <= s1;
      s1_sync <= s1_meta;
    end
  end

  // an steps 10 -> 11 -> 01 through a blank state, so it is never 00.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK0;
      cnt        <= '0;
      hold       <= '0;
      an         <= 2'b11;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cnt        <= cnt + 1'b1;
      case (state)
        BLANK0: if (cnt == BLANK_LAST) begin
          state <= SHOW0;
          cnt   <= '0;
          hold  <= s0_sync;
          an    <= 2'b10;
        end
        SHOW0: if (cnt == SHOW_LAST) begin
          state <= BLANK1;
          cnt   <= '0;
          an    <= 2'b11;
        end
        BLANK1: if (cnt == BLANK_LAST) begin
          state <= SHOW1;
          cnt   <= '0;
          hold  <= s1_sync;
          an    <= 2'b01;
        end
        default: if (cnt == SHOW_LAST) begin
          state      <= BLANK0;
          cnt        <= '0;
          an         <= 2'b11;
          frame_done <= 1'b1;
        end
      endcase
    end
  end

  assign seg = (state == SHOW0 || state == SHOW1) ? decode(hold) : 7'b1111111;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboard bench: a per-edge position model pushes expected outputs, a
// negedge checker pops and compares; directed checks cover the corner cases.
module tb_seg_scan_scheduler;

  localparam int RA = 4, BA = 2, LA = 2 * (RA + BA);
  localparam int RB = 1, BB = 1, LB = 2 * (RB + BB);

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] s0 = 4'h0, s1 = 4'h0;
  logic [1:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       fd_a, fd_b;

  int total = 0, bad = 0;
  bit run = 1'b0;
  exp_t qa[$], qb[$];

  logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg_scan_scheduler #(.REFRESH_CYCLES(RA), .BLANK_CYCLES(BA)) dut_a (
    .clk(clk), .reset(reset), .s0(s0), .s1(s1),
    .an(an_a), .seg(seg_a), .frame_done(fd_a));

  seg_scan_scheduler #(.REFRESH_CYCLES(RB), .BLANK_CYCLES(BB)) dut_b (
    .clk(clk), .reset(reset), .s0(s0), .s1(s1),
    .an(an_b), .seg(seg_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 0 = BLANK0, 1 = SHOW0, 2 = BLANK1, 3 = SHOW1 for cycle n after reset
  function automatic int phase(input int n, input int b, input int r);
    int p;
    p = n % (2 * (b + r));
    if (p < b) return 0;
    if (p < b + r) return 1;
    if (p < 2 * b + r) return 2;
    return 3;
  endfunction

  function automatic exp_t mk(input int ph, input logic [3:0] h0, input logic [3:0] h1, input logic fd);
    exp_t e;
    e.an  = (ph == 1) ? 2'b10 : (ph == 3) ? 2'b01 : 2'b11;
    e.seg = (ph == 1) ? dec[h0] : (ph == 3) ? dec[h1] : 7'b1111111;
    e.fd  = fd;
    return e;
  endfunction

  // model A: inputs seen two edges before a capture edge are what gets lit
  int na = 0, pa = 0;
  logic [3:0] ha0, ha1, a0d1, a0d2, a1d1, a1d2;
  always @(posedge clk) if (run) begin
    if (reset) begin
      na = 0; ha0 = 0; ha1 = 0;
      a0d1 = 0; a0d2 = 0; a1d1 = 0; a1d2 = 0;
    end else begin
      na++;
      if (na % LA == BA) ha0 = a0d2;
      if (na % LA == 2 * BA + RA) ha1 = a1d2;
      a0d2 = a0d1; a0d1 = s0;
      a1d2 = a1d1; a1d1 = s1;
    end
    pa = na % LA;
    qa.push_back(mk(phase(na, BA, RA), ha0, ha1, (na > 0) && (na % LA == 0)));
  end

  int nb = 0;
  logic [3:0] hb0, hb1, b0d1, b0d2, b1d1, b1d2;
  always @(posedge clk) if (run) begin
    if (reset) begin
      nb = 0; hb0 = 0; hb1 = 0;
      b0d1 = 0; b0d2 = 0; b1d1 = 0; b1d2 = 0;
    end else begin
      nb++;
      if (nb % LB == BB) hb0 = b0d2;
      if (nb % LB == 2 * BB + RB) hb1 = b1d2;
      b0d2 = b0d1; b0d1 = s0;
      b1d2 = b1d1; b1d1 = s1;
    end
    qb.push_back(mk(phase(nb, BB, RB), hb0, hb1, (nb > 0) && (nb % LB == 0)));
  end

  always @(negedge clk) if (run) begin
    exp_t e;
    chk("an_a_nonzero", 32'(an_a == 2'b00), 32'(0));
    chk("an_b_nonzero", 32'(an_b == 2'b00), 32'(0));
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_an", 32'(an_a), 32'(e.an));
      chk("a_seg", 32'(seg_a), 32'(e.seg));
      chk("a_fd", 32'(fd_a), 32'(e.fd));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_an", 32'(an_b), 32'(e.an));
      chk("b_seg", 32'(seg_b), 32'(e.seg));
      chk("b_fd", 32'(fd_b), 32'(e.fd));
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_pa(input int target);
    for (int i = 0; i < 100 && pa != target; i++) cyc(1);
    chk("wait_pa", 32'(pa), 32'(target));
  endtask

  initial begin
    logic [1:0] pat_b [4] = '{2'b11, 2'b10, 2'b11, 2'b01};
    int pulses, last, lat;
    run = 1'b1;
    cyc(3);
    chk("rst_an", 32'(an_a), 32'(2'b11));
    chk("rst_seg", 32'(seg_a), 32'(7'b1111111));
    chk("rst_fd", 32'(fd_a), 32'(0));
    reset = 1'b0;

    s0 = 4'h1; s1 = 4'h8;
    cyc(36);
    wait_pa(BA + 1);
    chk("p18_seg0", 32'(seg_a), 32'(7'b1111001));
    wait_pa(2 * BA + RA + 1);
    chk("p18_seg1", 32'(seg_a), 32'(7'b0000000));

    s1 = 4'h0;
    for (int v = 0; v < 16; v++) begin
      wait_pa(BA + RA);
      s0 = 4'(v);
      wait_pa(BA + 1);
      chk("sweep_seg", 32'(seg_a), 32'(dec[v]));
    end

    wait_pa(BA + RA);
    s0 = 4'h3;
    wait_pa(BA + 1);
    s0 = 4'h5;
    for (int i = 0; i < 3; i++) begin
      chk("mid_hold", 32'(seg_a), 32'(7'b0110000));
      cyc(1);
    end
    wait_pa(BA + 1);
    chk("mid_next", 32'(seg_a), 32'(7'b0010010));

    // free run 5 frames from reset
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    pulses = 0; last = -1;
    for (int i = 0; i < 60; i++) begin
      if (i < 8) chk("b_pattern", 32'(an_b), 32'(pat_b[i % 4]));
      if (fd_a) begin
        if (last >= 0) chk("fd_gap", 32'(i - last), 32'(12));
        pulses++;
        last = i;
      end
      cyc(1);
    end
    chk("fd_count", 32'(pulses), 32'(4));

    wait_pa(2 * BA + RA + 2);
    reset = 1'b1;
    cyc(1);
    chk("mrst_an", 32'(an_a), 32'(2'b11));
    chk("mrst_seg", 32'(seg_a), 32'(7'b1111111));
    chk("mrst_fd", 32'(fd_a), 32'(0));
    reset = 1'b0;
    lat = 0;
    while (an_a == 2'b11 && lat < 20) begin
      lat++;
      cyc(1);
    end
    chk("show0_lat", 32'(lat), 32'(BA));
    chk("show0_an", 32'(an_a), 32'(2'b10));

    cyc(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_scheduler.md
# seg_scan_scheduler

Time-multiplexing scheduler that shares one common-cathode/anode seven-segment bus between two digits. Each digit's hex value comes from its own 4-bit switch group. The block sequences the digit enables with a blanking dead time between digits to prevent ghosting, and decodes the active digit onto the shared segment lines. It sits in the top level next to the LED controller, clocked from the HSOSC-derived clock.

## Interface
- REFRESH_CYCLES, 24000: clock cycles each digit is lit. At 48 MHz this is 0.5 ms per digit, 1 kHz full frame. Must be ≥ 1.
- BLANK_CYCLES, 480: clock cycles both digits are dark before each digit is lit (10 µs). Must be ≥ 1.
- clk  in  1  system clock, from the internal oscillator.
- reset  in  1  synchronous, active-high reset.
- s0  in  4  hex value for digit 0; asynchronous switch input.
- s1  in  4  hex value for digit 1; asynchronous switch input.
- an  out  2  digit enables, active-low. an[0] = digit 0, an[1] = digit 1.
- seg  out  7  segments, active-low. seg[0]=a … seg[6]=g.
- frame_done  out  1  one-cycle pulse marking the end of each full scan frame.

## Operation
- Synchronizers
  - s0 and s1 each pass through a 2-flop synchronizer (s0_sync, s1_sync) before any use.
- FSM states: BLANK0 → SHOW0 → BLANK1 → SHOW1 → BLANK0.
- Phase counter
  - One phase counter, width $clog2(max(REFRESH_CYCLES, BLANK_CYCLES)).
  - Cleared on every state transition.
  - BLANKx lasts exactly BLANK_CYCLES cycles; SHOWx lasts exactly REFRESH_CYCLES cycles.
  - A transition occurs on the edge where the counter equals the phase length − 1.
- Digit capture
  - On the BLANK0→SHOW0 edge, s0_sync is loaded into a 4-bit hold register. On the BLANK1→SHOW1 edge, s1_sync is loaded instead.
  - The hold register is stable for the whole SHOW phase. Input changes mid-phase never alter the lit pattern.
- Outputs by state
  - BLANK0, BLANK1: an = 2'b11, seg = 7'b1111111.
  - SHOW0: an = 2'b10, seg = decode(hold).
  - SHOW1: an = 2'b01, seg = decode(hold).
- Decode (active-low, seg[6:0]): 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- frame_done is high for exactly the one cycle after the SHOW1→BLANK0 edge, i.e. the first BLANK0 cycle of a new frame. It is not asserted on the first BLANK0 after reset.
- Register-only outputs
  - an, seg and frame_done are registers or functions of registers only. There is no combinational path from s0/s1 to any output.
  - an never equals 2'b00 in any cycle, including across transitions and reset.

## Timing
- Reset state: state = BLANK0, counter = 0, hold = 0, synchronizers = 0, an = 2'b11, seg = 7'b1111111, frame_done = 0.
- Reset mid-operation: on the next clk edge with reset = 1, all of the above apply regardless of state. Reset has priority over every transition.
- After reset deasserts, SHOW0 begins BLANK_CYCLES cycles later.
- Frame period is exactly 2·(BLANK_CYCLES + REFRESH_CYCLES) cycles. frame_done pulses once per period.
- Input-to-display latency: 2 cycles of synchronization plus the wait until the next matching BLANK→SHOW edge.
- Boundary: BLANK_CYCLES = 1 or REFRESH_CYCLES = 1 gives single-cycle phases; no state is skipped or repeated.
- Boundary: input change on the same edge as capture. The value present in s0_sync/s1_sync on that edge is the one captured.

## Test plan
All scenarios use REFRESH_CYCLES = 4 and BLANK_CYCLES = 2.
- Reset, then hold s0 = 4'h1, s1 = 4'h8 → repeating 12-cycle pattern: 2× (an 11, seg 1111111), 4× (an 10, seg 1111001), 2× (an 11, seg 1111111), 4× (an 01, seg 0000000).
- Sweep s0 through 0–F, one value per frame, with s1 = 4'h0 → each SHOW0 phase shows the decode entry listed above for that frame's s0 value.
- Change s0 from 4'h3 to 4'h5 in the 2nd cycle of SHOW0 → remaining SHOW0 cycles still show 0110000; the next SHOW0 shows 0010010.
- Free-run 5 frames → frame_done high exactly 4 times, exactly 12 cycles apart. Assertion: an != 2'b00 in every cycle.
- Assert reset for 1 cycle in the 3rd cycle of SHOW1 → next cycle: an = 11, seg = 1111111, frame_done = 0. SHOW0 restarts 2 cycles after reset deasserts.
- Rebuild with REFRESH_CYCLES = 1 and BLANK_CYCLES = 1 → 4-cycle frame: an = 11, 10, 11, 01.
